// File: rtl/hw_event_tx.sv
// Hardware->software event channel: latches per-object hits, stamps them with sword
// position, queues them and hands them to the CPU one word at a time over sig/ack.
module hw_event_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int Y_TOP      = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hit_pulse,
    input  logic [9:0]  sword_x,
    input  logic [9:0]  sword_y,
    input  logic [1:0]  to_hw_evt_ack,
    output logic [31:0] to_sw_evt_port,
    output logic [1:0]  to_sw_evt_sig,
    output logic [6:0]  fifo_count,
    output logic        pending_any
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);
    localparam logic [9:0] Y_TOP_C = 10'(Y_TOP);

    // Handshake: sig=1 means the port holds a valid word; ack=1 while sig=1 consumes it.
    // Sig then drops and the next word is offered only after ack returns to 0.
    // Ack values 2 and 3 are treated as "not 1 and not 0" everywhere.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pending_q;
    logic [15:0]   sel_mask;
    logic [3:0]    sel_idx;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [6:0]    count_q;
    logic [7:0]    seq_q;
    logic [9:0]    y_sw;
    logic [23:0]   head;
    logic          push, pop, load;

    // Lowest-index pending object wins the single push slot.
    always_comb begin
        sel_idx  = 4'd0;
        sel_mask = 16'd0;
        for (int i = 15; i >= 1; i--) begin
            if (pending_q[i]) begin
                sel_idx  = 4'(i);
                sel_mask = 16'd1 << i;
            end
        end
    end

    assign y_sw = (sword_y <= Y_TOP_C) ? (Y_TOP_C - sword_y) : 10'd0;
    assign pop  = (state_q == SEND) && (to_hw_evt_ack == 2'd1);
    assign push = (|pending_q) && ((count_q != DEPTH_C) || pop);
    assign load = (state_q == IDLE) && (count_q != 7'd0) && (to_hw_evt_ack == 2'd0);
    assign head = mem[rd_ptr];

    // Bit 0 is masked so it never becomes pending; a new hit beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 16'd0;
        end else begin
            pending_q <= (pending_q & ~(push ? sel_mask : 16'd0)) | (hit_pulse & 16'hFFFE);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_idx, sword_x, y_sw};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 7'd0;
            seq_q   <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                seq_q  <= seq_q + 8'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 7'd1;
                2'b01:   count_q <= count_q - 7'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SEND;
            SEND:    if (to_hw_evt_ack == 2'd1) state_d = REL;
            REL:     if (to_hw_evt_ack == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        to_sw_evt_sig = (state_q == SEND) ? 2'd1 : 2'd0;
        fifo_count    = count_q;
        pending_any   = |pending_q;
    end

    // Port only reloads when leaving IDLE, so it is frozen through SEND and REL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_sw_evt_port <= 32'd0;
        end else if (load) begin
            to_sw_evt_port <= {seq_q, head[9:0], head[19:10], head[23:20]};
        end
    end

endmodule

// File: tb/tb_hw_event_tx.sv
// Bench for hw_event_tx: a per-cycle behavioural model (pending set + entry queue)
// predicts every delivered word, occupancy and pending flag.
module tb_hw_event_tx;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [15:0] hit_pulse;
  logic [9:0]  sword_x;
  logic [9:0]  sword_y;
  logic [1:0]  to_hw_evt_ack;
  logic [31:0] to_sw_evt_port;
  logic [1:0]  to_sw_evt_sig;
  logic [6:0]  fifo_count;
  logic        pending_any;

  hw_event_tx #(.FIFO_DEPTH(DEPTH), .Y_TOP(480)) dut (
    .clk(clk),
    .reset(reset),
    .hit_pulse(hit_pulse),
    .sword_x(sword_x),
    .sword_y(sword_y),
    .to_hw_evt_ack(to_hw_evt_ack),
    .to_sw_evt_port(to_sw_evt_port),
    .to_sw_evt_sig(to_sw_evt_sig),
    .fifo_count(fifo_count),
    .pending_any(pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          mode = 0;          // 0 prompt consumer, 1 random consumer, 2 never acks
  logic [23:0] exp_q[$];          // model FIFO: {idx, x, y_sw}
  logic [31:0] got_q[$];          // words seen on the port
  logic [15:0] mpend;
  logic [7:0]  exp_seq;
  logic        prev_sig;
  logic [31:0] last_port;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;

  function automatic logic [9:0] ysw_of(input logic [9:0] y);
    if (int'(y) <= 480) return 10'(480 - int'(y));
    return 10'd0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    got_q.delete();
    mpend    = 16'd0;
    exp_seq  = 8'd0;
    prev_sig = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hit_pulse = 16'd0;
    to_hw_evt_ack = 2'd0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: check the state left by the previous edge, act as software, advance the model.
  task automatic cycle(input logic [15:0] pulse);
    logic        sig1, pop, full_before;
    logic [1:0]  a;
    logic [31:0] exp_w;
    int          lo;
    @(negedge clk);
    cyc++;
    checks++;
    if (fifo_count !== 7'(exp_q.size())) begin
      errors++;
      $display("FAIL fifo_count cyc %0d got %0d exp %0d", cyc, fifo_count, exp_q.size());
    end
    checks++;
    if (pending_any !== (mpend != 16'd0)) begin
      errors++;
      $display("FAIL pending_any cyc %0d got %b exp %b", cyc, pending_any, (mpend != 16'd0));
    end
    sig1 = (to_sw_evt_sig === 2'd1);
    if (sig1 && !prev_sig) begin
      rise_cyc = cyc;
      got_q.push_back(to_sw_evt_port);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_word cyc %0d got %h exp none", cyc, to_sw_evt_port);
      end else begin
        exp_w = {exp_seq, exp_q[0][9:0], exp_q[0][19:10], exp_q[0][23:20]};
        if (to_sw_evt_port !== exp_w) begin
          errors++;
          $display("FAIL word cyc %0d got %h exp %h", cyc, to_sw_evt_port, exp_w);
        end
      end
    end else if (sig1) begin
      checks++;
      if (to_sw_evt_port !== last_port) begin
        errors++;
        $display("FAIL port_stable cyc %0d got %h exp %h", cyc, to_sw_evt_port, last_port);
      end
    end
    if (sig1) last_port = to_sw_evt_port;
    prev_sig = sig1;

    case (mode)
      0: a = sig1 ? 2'd1 : 2'd0;
      1: begin
        if (sig1) a = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 1) * 2);
        else      a = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
      end
      default: a = 2'd0;
    endcase
    pop = sig1 && (a == 2'd1);

    hit_pulse     = pulse;
    sword_x       = cur_x;
    sword_y       = cur_y;
    to_hw_evt_ack = a;

    full_before = (exp_q.size() >= DEPTH);
    if (pop) begin
      void'(exp_q.pop_front());
      exp_seq++;
    end
    if (mpend != 16'd0 && (!full_before || pop)) begin
      lo = 0;
      for (int i = 1; i < 16; i++) if (mpend[i] && lo == 0) lo = i;
      exp_q.push_back({4'(lo), cur_x, ysw_of(cur_y)});
      mpend[lo] = 1'b0;
    end
    mpend = mpend | (pulse & 16'hFFFE);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mpend != 16'd0 || prev_sig) && k < 4000) begin
      cycle(16'd0);
      k++;
    end
    repeat (3) cycle(16'd0);
    checks++;
    if (k >= 4000) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles exp < 4000", k);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (to_sw_evt_sig !== 2'd0 || to_sw_evt_port !== 32'd0 || fifo_count !== 7'd0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got sig %0d port %h cnt %0d pa %b exp 0 0 0 0",
               to_sw_evt_sig, to_sw_evt_port, fifo_count, pending_any);
    end
  endtask

  task automatic test_single();
    int p;
    do_reset();
    mode = 0;
    cur_x = 10'd100;
    cur_y = 10'd80;
    p = cyc + 1;
    cycle(16'h0008);
    drain();
    checks++;
    if (rise_cyc != p + 3) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", rise_cyc - p, 3);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0064_0643) begin
      errors++;
      $display("FAIL single_word got n=%0d w=%h exp n=1 w=00640643", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    checks++;
    if (to_sw_evt_sig !== 2'd0) begin
      errors++;
      $display("FAIL sig_release got %0d exp 0", to_sw_evt_sig);
    end
  endtask

  task automatic test_burst();
    logic [3:0] idx_e[3];
    idx_e[0] = 4'd1; idx_e[1] = 4'd2; idx_e[2] = 4'd15;
    do_reset();
    mode = 0;
    cur_x = 10'd5;
    cur_y = 10'd6;
    cycle(16'h8006);
    drain();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL burst_count got %0d exp 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i][3:0] !== idx_e[i] || got_q[i][31:24] !== 8'(i)) begin
          errors++;
          $display("FAIL burst_order i %0d got idx %0d seq %0d exp idx %0d seq %0d",
                   i, got_q[i][3:0], got_q[i][31:24], idx_e[i], i);
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    mode = 2;
    cur_x = 10'd300;
    cur_y = 10'd200;
    cycle(16'h07FE);
    repeat (20) cycle(16'd0);
    checks++;
    if (fifo_count !== 7'd8 || pending_any !== 1'b1) begin
      errors++;
      $display("FAIL full_hold got cnt %0d pa %b exp cnt 8 pa 1", fifo_count, pending_any);
    end
    mode = 0;
    drain();
    checks++;
    if (got_q.size() != 10) begin
      errors++;
      $display("FAIL full_delivered got %0d exp 10", got_q.size());
    end
  endtask

  task automatic test_clamp();
    do_reset();
    mode = 0;
    cur_x = 10'd7;
    cur_y = 10'd500;
    cycle(16'h0002);
    repeat (6) cycle(16'd0);
    cur_y = 10'd0;
    cycle(16'h0004);
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0][23:14] !== 10'd0 || got_q[1][23:14] !== 10'd480) begin
      errors++;
      $display("FAIL clamp got n=%0d y0=%0d y1=%0d exp n=2 y0=0 y1=480", got_q.size(),
               (got_q.size() > 0) ? got_q[0][23:14] : 10'hx,
               (got_q.size() > 1) ? got_q[1][23:14] : 10'hx);
    end
  endtask

  task automatic test_merge();
    do_reset();
    mode = 2;
    cur_x = 10'd11;
    cur_y = 10'd22;
    cycle(16'h01FE);
    repeat (10) cycle(16'd0);
    repeat (10) cycle(16'h0200);
    repeat (2) cycle(16'd0);
    checks++;
    if (fifo_count !== 7'd8 || pending_any !== 1'b1) begin
      errors++;
      $display("FAIL merge_hold got cnt %0d pa %b exp cnt 8 pa 1", fifo_count, pending_any);
    end
    mode = 0;
    drain();
    checks++;
    if (got_q.size() != 9) begin
      errors++;
      $display("FAIL merge_count got %0d exp 9", got_q.size());
    end
  endtask

  task automatic test_seq_wrap();
    logic wrapped;
    do_reset();
    mode = 1;
    for (int k = 0; k < 20000 && got_q.size() < 260; k++) begin
      cur_x = 10'($urandom_range(0, 1023));
      cur_y = 10'($urandom_range(0, 1023));
      cycle(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0);
    end
    drain();
    wrapped = 1'b0;
    for (int i = 0; i + 1 < got_q.size(); i++)
      if (got_q[i][31:24] == 8'd255 && got_q[i+1][31:24] == 8'd0) wrapped = 1'b1;
    checks++;
    if (got_q.size() < 257 || !wrapped) begin
      errors++;
      $display("FAIL seq_wrap got n=%0d wrap=%b exp n>=257 wrap=1", got_q.size(), wrapped);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2;
    cur_x = 10'd40;
    cur_y = 10'd50;
    cycle(16'h000E);
    repeat (6) cycle(16'd0);
    checks++;
    if (to_sw_evt_sig !== 2'd1) begin
      errors++;
      $display("FAIL mid_setup got sig %0d exp 1", to_sw_evt_sig);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (to_sw_evt_sig !== 2'd0 || to_sw_evt_port !== 32'd0 || fifo_count !== 7'd0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sig %0d port %h cnt %0d pa %b exp 0 0 0 0",
               to_sw_evt_sig, to_sw_evt_port, fifo_count, pending_any);
    end
    hit_pulse = 16'd0;
    to_hw_evt_ack = 2'd0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    cycle(16'h0010);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0][31:24] !== 8'd0 || got_q[0][3:0] !== 4'd4) begin
      errors++;
      $display("FAIL post_reset_seq got n=%0d w=%h exp n=1 seq 0 idx 4", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  initial begin
    reset = 1'b1;
    hit_pulse = 16'd0;
    sword_x = 10'd0;
    sword_y = 10'd0;
    to_hw_evt_ack = 2'd0;
    cur_x = 10'd0;
    cur_y = 10'd0;
    last_port = 32'd0;
    model_clear();
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_clamp();
    test_merge();
    test_seq_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
